// File: rtl/qc_ldpc_enc.sv
// Streaming systematic QC-LDPC encoder: K message blocks in, full codeword plus
// BPSK LLR vector (decoder `sig` layout) out.
module qc_ldpc_enc #(
    parameter int                data_w  = 8,
    parameter int                R       = 8,
    parameter int                C       = 4,
    parameter int                D       = 8,
    parameter logic [data_w-1:0] LLR_MAG = 8'd16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [(R-C)*C*data_w-1:0] gmtx,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [D-1:0]              in_blk,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [R*D-1:0]            cw,
    output logic [R*D*data_w-1:0]     llr,
    output logic                      busy
);

    localparam int K   = R - C;
    localparam int G_W = K * C * data_w;
    localparam logic [data_w-1:0] LLR_NEG = ~LLR_MAG + 1'b1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                  state_q, state_d;
    logic [data_w-1:0]       cnt_q, cnt_d;
    logic [C-1:0][D-1:0]     par_q, par_d;
    logic [K-1:0][D-1:0]     msg_q, msg_d;
    logic [G_W-1:0]          gmtx_q, gmtx_d;
    logic [R*D-1:0]          cw_q, cw_d;
    logic                    accept;

    // rot(x,s)[k] = x[(k+s) mod D]; shifting a doubled copy gives the wrap for free
    function automatic logic [D-1:0] rot(input logic [D-1:0] x, input logic [data_w-1:0] e);
        int unsigned s;
        s = e % D;
        return D'({x, x} >> s);
    endfunction

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign cw        = cw_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        msg_d   = msg_q;
        gmtx_d  = gmtx_q;
        cw_d    = cw_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    // first beat uses the live table; later beats use the latched copy
                    gmtx_d = gmtx;
                    for (int unsigned c = 0; c < C; c++)
                        par_d[c] = rot(in_blk, gmtx[c*data_w +: data_w]);
                    msg_d[0] = in_blk;
                    cnt_d    = data_w'(1);
                    if (K == 1) begin
                        state_d = DONE;
                        cw_d    = {par_d, msg_d};
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    for (int unsigned m = 0; m < K; m++) begin
                        if (cnt_q == data_w'(m)) begin
                            msg_d[m] = in_blk;
                            for (int unsigned c = 0; c < C; c++)
                                par_d[c] = par_q[c] ^ rot(in_blk, gmtx_q[(m*C+c)*data_w +: data_w]);
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == data_w'(K-1)) begin
                        state_d = DONE;
                        cw_d    = {par_d, msg_d};
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    par_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            par_q   <= '0;
            msg_q   <= '0;
            gmtx_q  <= '0;
            cw_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            msg_q   <= msg_d;
            gmtx_q  <= gmtx_d;
            cw_q    <= cw_d;
        end
    end

    always_comb begin
        llr = '0;
        for (int unsigned i = 0; i < R*D; i++)
            llr[i*data_w +: data_w] = cw_q[i] ? LLR_NEG : LLR_MAG;
    end

endmodule

// File: doc/qc_ldpc_enc.md
Name: qc_ldpc_enc

Overview:
Streaming systematic quasi-cyclic LDPC encoder. It is the transmit-side counterpart of the LDPC decoder top.
- Accepts K = R-C message blocks of D bits, one block per handshake beat.
- Accumulates C parity blocks using cyclic-shifted XOR driven by a packed generator shift table.
- Emits the full R*D-bit codeword, plus a BPSK-mapped LLR vector in exactly the decoder's `sig` format. This lets the two blocks be chained in loopback benches.

Parameters:
- data_w, 8, width of each shift entry and of each output LLR.
- R, 8, codeword length in D-bit blocks.
- C, 4, number of parity blocks; message blocks K = R-C.
- D, 8, circulant size (bits per block).
- LLR_MAG, 8'd16, magnitude emitted for every codeword bit; must be < 2^(data_w-1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- gmtx  in  (R-C)*C*data_w  shift table; entry (m,c) at gmtx[(m*C+c)*data_w +: data_w], used modulo D.
- in_valid  in  1  message block valid.
- in_ready  out  1  encoder can accept a block.
- in_blk  in  D  message block; bit k is bit k of the block.
- out_valid  out  1  codeword available.
- out_ready  in  1  consumer accepts codeword.
- cw  out  R*D  codeword, registered.
- llr  out  R*D*data_w  BPSK LLRs; llr[i*data_w +: data_w] corresponds to cw[i].
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Rotation: rot(x,s)[k] = x[(k+s) mod D], where s = entry mod D. Shift values >= D wrap, so 9 behaves as 1 for D=8.
- FSM states: IDLE, LOAD, DONE.
- Reset (async, any state, including mid-frame):
  - state = IDLE, beat counter = 0, parity regs = 0, latched gmtx = 0.
  - cw = 0, out_valid = 0, in_ready = 1, busy = 0.
- in_ready = 1 in IDLE and LOAD, 0 in DONE. A beat is accepted when in_valid & in_ready.
- IDLE, on accept (beat m=0):
  - Latch gmtx.
  - parity_c = rot(in_blk, live gmtx(0,c)) for every c.
  - Store message block 0; counter = 1.
  - Go to LOAD, or go directly to DONE if K==1.
- LOAD, on accept (beat m = counter):
  - parity_c ^= rot(in_blk, latched gmtx(m,c)).
  - Store message block m; counter++.
  - On beat m = K-1, go to DONE.
- LOAD with no accept: hold all state. in_valid gaps of any length are allowed.
- Entering DONE: cw is loaded in the same edge as the last beat, so out_valid rises exactly 1 cycle after the last accepted beat.
  - cw[m*D +: D] = message block m, for m < K.
  - cw[(K+c)*D +: D] = final parity_c, for c < C.
- DONE:
  - cw, llr and out_valid hold stable until out_valid & out_ready.
  - On that handshake, go to IDLE; out_valid = 0 next cycle; cw retains its value; counter and parity regs clear.
- No new beat is accepted in the handshake cycle, because in_ready = 0 in DONE.
- llr is combinational from cw: bit 0 gives +LLR_MAG, bit 1 gives -LLR_MAG (two's complement, data_w bits). After reset, llr is all +LLR_MAG.
- gmtx changes after the first beat of a frame have no effect until the next frame.
- Counter width: data_w bits. The design requires K < 2^data_w.

Test Plan (R=8, C=4, D=8, data_w=8, LLR_MAG=16):
1. All gmtx=0; beats 0x01,0x02,0x04,0x08 back-to-back -> out_valid 1 cycle after 4th beat; cw=0x0F0F0F0F_08040201.
2. gmtx(0,0)=1, others 0; beats 0x01,0,0,0 -> parity0=0x80, parity1..3=0x01; repeat with gmtx(0,0)=9 -> identical cw.
3. Test-1 frame with out_ready low for 5 cycles -> cw stable, in_ready=0, busy=1 throughout; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
4. Reset asserted after 2 accepted beats -> out_valid=0, in_ready=1, busy=0, cw=0 immediately; a fresh Test-1 frame then gives the Test-1 cw exactly.
5. Test-1 frame with in_valid idle 3 cycles between each beat -> same cw; out_valid 1 cycle after last beat.
6. LLR check on Test-1 result -> llr byte for cw bit 0 (=1) is 0xF0, for cw bit 8 (=0) is 0x10; after reset all bytes 0x10.
